reg_file_sb: RTL and testbench
==============================

// Module: reg_file_sb
// PURPOSE
//  Parametrised, clocked integer register file with N async read ports, one write port and an
//  integrated busy scoreboard. Sits between decode (reads, issue marking) and writeback.
//  Successor to the single-cycle combinational register array, and adds:
//  - a clock
//  - a synchronous reset
//  - a hardwired zero register
//  - per-register pending-write tracking for hazard stalls
// PARAMETERS
//  XLEN      32  data width of each register
//  DEPTH     32  number of registers; power of two
//  AW        $clog2(DEPTH)  register address width; derived, do not override
//  NRD       2   number of read ports (1..4)
//  ZERO_REG  1   1: register 0 reads 0, ignores writes and issues; 0: register 0 is ordinary
// PORTS
//  clk_i          in   1         clock; all state changes on rising edge
//  rst_i          in   1         synchronous reset, active-high
//  rd_addr_i      in   NRD*AW    read addresses; port k at [k*AW +: AW]
//  rd_dat_o       out  NRD*XLEN  read data; port k at [k*XLEN +: XLEN]
//  rd_busy_o      out  NRD       1 = the addressed register has a pending write
//  wr_en_i        in   1         writeback strobe
//  wr_addr_i      in   AW        writeback destination
//  wr_dat_i       in   XLEN      writeback data
//  issue_en_i     in   1         instruction issued that will write issue_addr_i
//  issue_addr_i   in   AW        destination being reserved
//  busy_vec_o     out  DEPTH     full scoreboard, bit i = register i pending
//  wb_nobusy_o    out  1         1-cycle pulse: last-cycle write hit a non-busy register
// BEHAVIOUR
//  - Reset: one clock, rst_i=1, synchronous, active-high. On that edge:
//    all registers <= 0, busy_vec_o <= 0, wb_nobusy_o <= 0.
//    rst_i overrides any same-cycle write or issue.
//    Reset mid-operation discards all pending reservations.
//  - Read: combinational, zero latency.
//    rd_dat_o = reg[rd_addr]; rd_busy_o = busy[rd_addr].
//    Ports are independent; duplicate addresses across ports are legal.
//  - Write: on the rising edge with wr_en_i=1, reg[wr_addr_i] <= wr_dat_i, and
//    busy[wr_addr_i] <= 0 unless it is re-reserved the same cycle.
//  - Issue: on the rising edge with issue_en_i=1, busy[issue_addr_i] <= 1.
//  - Simultaneous write and issue to the same address: the data is written and busy stays 1
//    (the newer producer wins). Different addresses: both take effect independently.
//  - Re-issue of an already-busy register: it stays busy; there is no count (single outstanding
//    producer per register).
//  - wb_nobusy_o: registered; asserts for one cycle after a write to an address whose busy bit
//    was 0 before the edge (addr 0 excluded when ZERO_REG=1). The write is still performed.
//  - ZERO_REG=1: rd_dat_o=0 and rd_busy_o=0 for address 0; writes and issues to 0 are dropped.
//    busy_vec_o[0] is constant 0.
//  - Address range: DEPTH is a power of two, so every address is valid. There are no
//    out-of-range cases.
// CONFIGURATION
//  - REG_FILE_SB_BYPASS_EN defined:
//    - Write-to-read forwarding. If wr_en_i=1 and rd_addr==wr_addr_i (and not zero-reg), then
//      rd_dat_o=wr_dat_i in the same cycle.
//    - rd_busy_o=0 for that port, unless issue_en_i=1 and issue_addr_i==wr_addr_i that cycle,
//      in which case rd_busy_o=1.
//  - Undefined: reads return the pre-edge stored value and busy bit. The forwarded data is
//    visible on the cycle after the write.
// STRUCTURE
//  - Package regfile_pkg:
//    - XLEN_DEF = 32, DEPTH_DEF = 32
//    - typedef reg_addr_t (logic [AW-1:0])
//    - ZERO_IDX = 0
//  - Sub-module reg_scoreboard holds busy_vec and the wb_nobusy logic.
//    - Inputs: wr/issue strobes and addresses, plus rst_i.
//    - Output: busy_vec.
//  - The data array and read muxing stay in reg_file_sb.
// TESTING
//  1. Reset: write 0xDEADBEEF to r5, then assert rst_i for one edge.
//     -> rd r5 = 0, busy_vec_o = 0, wb_nobusy_o = 0.
//  2. Zero register: wr r0 = 0x1234 and issue r0.
//     -> rd r0 = 0, rd_busy_o = 0, busy_vec_o[0] = 0, no wb_nobusy_o pulse.
//  3. Scoreboard: issue r7; next cycle rd r7 -> rd_busy_o = 1. Write r7 = 0xA5A5A5A5.
//     -> next cycle rd r7 = 0xA5A5A5A5, rd_busy_o = 0.
//  4. Same-cycle write and issue to r3 = 0x55.
//     -> next cycle rd r3 = 0x55 and busy_vec_o[3] = 1.
//  5. Write r9 = 0x77 with r9 not busy.
//     -> wb_nobusy_o = 1 for exactly one cycle; rd r9 = 0x77.
//  6. Bypass: r2 busy holding 0x11; write r2 = 0x22 while reading r2 on ports 0 and 1.
//     -> with the macro: both ports read 0x22 and rd_busy_o = 0 the same cycle.
//     -> without it: both ports read 0x11, rd_busy_o = 1, then 0x22 on the next cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared sizing defaults and address type for the scoreboarded register file.
package regfile_pkg;

   localparam int unsigned XLEN_DEF  = 32;
   localparam int unsigned DEPTH_DEF = 32;
   localparam int unsigned AW_DEF    = $clog2(DEPTH_DEF);
   localparam int unsigned ZERO_IDX  = 0;

   typedef logic [AW_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write tracking plus the write-to-idle-register pulse.
module reg_scoreboard
   import regfile_pkg::*;
#(
   parameter int unsigned DEPTH    = DEPTH_DEF,
   parameter int unsigned AW       = $clog2(DEPTH),
   parameter int unsigned ZERO_REG = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             wr_en_i,
   input  logic [AW-1:0]    wr_addr_i,
   input  logic             issue_en_i,
   input  logic [AW-1:0]    issue_addr_i,
   output logic [DEPTH-1:0] busy_vec_o,
   output logic             wb_nobusy_o
);

   logic [DEPTH-1:0] busy_d, busy_q;
   logic             nobusy_d, nobusy_q;
   logic             wr_ok, iss_ok;
   logic [DEPTH-1:0] zero_mask;

   assign wr_ok  = wr_en_i && !((ZERO_REG != 0) && (wr_addr_i == AW'(ZERO_IDX)));
   assign iss_ok = issue_en_i && !((ZERO_REG != 0) && (issue_addr_i == AW'(ZERO_IDX)));

   // Issue is applied after the write clear so a same-cycle re-reservation wins.
   always_comb begin
      busy_d = busy_q;
      if (wr_ok) begin
         busy_d[wr_addr_i] = 1'b0;
      end
      if (iss_ok) begin
         busy_d[issue_addr_i] = 1'b1;
      end
      nobusy_d = wr_ok && !busy_q[wr_addr_i];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         busy_q   <= '0;
         nobusy_q <= 1'b0;
      end else begin
         busy_q   <= busy_d;
         nobusy_q <= nobusy_d;
      end
   end

   assign zero_mask   = (ZERO_REG != 0) ? DEPTH'(1) : '0;
   assign busy_vec_o  = busy_q & ~zero_mask;
   assign wb_nobusy_o = nobusy_q;

endmodule

// File: rtl/reg_file_sb.sv
// Clocked register file with async read ports and busy scoreboard.
// Define REG_FILE_SB_BYPASS_EN for same-cycle write-to-read forwarding.
module reg_file_sb
   import regfile_pkg::*;
#(
   parameter int unsigned XLEN     = XLEN_DEF,
   parameter int unsigned DEPTH    = DEPTH_DEF,
   parameter int unsigned AW       = $clog2(DEPTH),
   parameter int unsigned NRD      = 2,
   parameter int unsigned ZERO_REG = 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [NRD*AW-1:0]   rd_addr_i,
   output logic [NRD*XLEN-1:0] rd_dat_o,
   output logic [NRD-1:0]      rd_busy_o,
   input  logic                wr_en_i,
   input  logic [AW-1:0]       wr_addr_i,
   input  logic [XLEN-1:0]     wr_dat_i,
   input  logic                issue_en_i,
   input  logic [AW-1:0]       issue_addr_i,
   output logic [DEPTH-1:0]    busy_vec_o,
   output logic                wb_nobusy_o
);

   logic [XLEN-1:0] mem_q [DEPTH];
   logic            wr_ok;
   logic [AW-1:0]   addr;

   assign wr_ok = wr_en_i && !((ZERO_REG != 0) && (wr_addr_i == AW'(ZERO_IDX)));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_ok) begin
         mem_q[wr_addr_i] <= wr_dat_i;
      end
   end

   reg_scoreboard #(
      .DEPTH    (DEPTH),
      .AW       (AW),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .wr_en_i      (wr_en_i),
      .wr_addr_i    (wr_addr_i),
      .issue_en_i   (issue_en_i),
      .issue_addr_i (issue_addr_i),
      .busy_vec_o   (busy_vec_o),
      .wb_nobusy_o  (wb_nobusy_o)
   );

   always_comb begin
      rd_dat_o  = '0;
      rd_busy_o = '0;
      addr      = '0;
      for (int k = 0; k < NRD; k++) begin
         addr = rd_addr_i[k*AW +: AW];
         if (!((ZERO_REG != 0) && (addr == AW'(ZERO_IDX)))) begin
            rd_dat_o[k*XLEN +: XLEN] = mem_q[addr];
            rd_busy_o[k]             = busy_vec_o[addr];
`ifdef REG_FILE_SB_BYPASS_EN
            // Forwarded data is final unless the same register is re-reserved this cycle.
            if (wr_ok && (addr == wr_addr_i)) begin
               rd_dat_o[k*XLEN +: XLEN] = wr_dat_i;
               rd_busy_o[k]             = issue_en_i && (issue_addr_i == wr_addr_i);
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed table-driven bench for reg_file_sb (default parameters, 2 read ports).
module tb_reg_file_sb;
   import regfile_pkg::*;

   typedef struct {
      logic        rst;
      logic        wr_en;
      reg_addr_t   wr_addr;
      logic [31:0] wr_dat;
      logic        iss_en;
      reg_addr_t   iss_addr;
      reg_addr_t   rd0;
      reg_addr_t   rd1;
      logic [31:0] exp_d0;
      logic [31:0] exp_d1;
      logic [1:0]  exp_busy;
      logic [31:0] exp_vec;
      logic        exp_nobusy;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_i;
   logic [9:0]  rd_addr_i;
   logic [63:0] rd_dat_o;
   logic [1:0]  rd_busy_o;
   logic        wr_en_i;
   reg_addr_t   wr_addr_i;
   logic [31:0] wr_dat_i;
   logic        issue_en_i;
   reg_addr_t   issue_addr_i;
   logic [31:0] busy_vec_o;
   logic        wb_nobusy_o;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   reg_file_sb dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .rd_addr_i    (rd_addr_i),
      .rd_dat_o     (rd_dat_o),
      .rd_busy_o    (rd_busy_o),
      .wr_en_i      (wr_en_i),
      .wr_addr_i    (wr_addr_i),
      .wr_dat_i     (wr_dat_i),
      .issue_en_i   (issue_en_i),
      .issue_addr_i (issue_addr_i),
      .busy_vec_o   (busy_vec_o),
      .wb_nobusy_o  (wb_nobusy_o)
   );

   function automatic vec_t mk(input logic rst, input logic we, input int wa, input logic [31:0] wd,
                               input logic ie, input int ia, input int r0, input int r1,
                               input logic [31:0] d0, input logic [31:0] d1, input logic [1:0] b,
                               input logic [31:0] vec, input logic nb);
      vec_t v;
      v.rst = rst; v.wr_en = we; v.wr_addr = reg_addr_t'(wa); v.wr_dat = wd;
      v.iss_en = ie; v.iss_addr = reg_addr_t'(ia);
      v.rd0 = reg_addr_t'(r0); v.rd1 = reg_addr_t'(r1);
      v.exp_d0 = d0; v.exp_d1 = d1; v.exp_busy = b; v.exp_vec = vec; v.exp_nobusy = nb;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s step %0d: got %h, wanted %h", name, idx, act, exp);
      end
   endtask

   // Drive one cycle of inputs, then check outputs before the rising edge.
   task automatic apply(input vec_t v, input int idx);
      @(negedge clk);
      rst_i        = v.rst;
      wr_en_i      = v.wr_en;
      wr_addr_i    = v.wr_addr;
      wr_dat_i     = v.wr_dat;
      issue_en_i   = v.iss_en;
      issue_addr_i = v.iss_addr;
      rd_addr_i    = {v.rd1, v.rd0};
      #1;
      chk("rd_dat0", idx, rd_dat_o[31:0], v.exp_d0);
      chk("rd_dat1", idx, rd_dat_o[63:32], v.exp_d1);
      chk("rd_busy", idx, {30'd0, rd_busy_o}, {30'd0, v.exp_busy});
      chk("busy_vec", idx, busy_vec_o, v.exp_vec);
      chk("wb_nobusy", idx, {31'd0, wb_nobusy_o}, {31'd0, v.exp_nobusy});
   endtask

   vec_t tbl[20];
   vec_t v;

   initial begin
      rst_i = 1'b1; wr_en_i = 1'b0; wr_addr_i = '0; wr_dat_i = '0;
      issue_en_i = 1'b0; issue_addr_i = '0; rd_addr_i = '0;
      @(posedge clk);

      //           rst we wa wdat          ie ia r0  r1  d0            d1          busy  vec        nb
      tbl[0]  = mk(0, 1, 5, 32'hDEADBEEF, 0, 0, 1,  0,  32'h0,        32'h0,      2'b00, 32'h0,     0);
      tbl[1]  = mk(1, 0, 0, 32'h0,        0, 0, 5,  0,  32'hDEADBEEF, 32'h0,      2'b00, 32'h0,     1);
      tbl[2]  = mk(0, 0, 0, 32'h0,        0, 0, 5,  0,  32'h0,        32'h0,      2'b00, 32'h0,     0);
      tbl[3]  = mk(0, 1, 0, 32'h1234,     1, 0, 0,  0,  32'h0,        32'h0,      2'b00, 32'h0,     0);
      tbl[4]  = mk(0, 0, 0, 32'h0,        0, 0, 0,  0,  32'h0,        32'h0,      2'b00, 32'h0,     0);
      tbl[5]  = mk(0, 0, 0, 32'h0,        1, 7, 7,  0,  32'h0,        32'h0,      2'b00, 32'h0,     0);
      tbl[6]  = mk(0, 0, 0, 32'h0,        0, 0, 7,  0,  32'h0,        32'h0,      2'b01, 32'h80,    0);
      tbl[7]  = mk(0, 1, 7, 32'hA5A5A5A5, 0, 0, 6,  6,  32'h0,        32'h0,      2'b00, 32'h80,    0);
      tbl[8]  = mk(0, 0, 0, 32'h0,        0, 0, 7,  7,  32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00, 32'h0,   0);
      tbl[9]  = mk(0, 1, 3, 32'h55,       1, 3, 1,  1,  32'h0,        32'h0,      2'b00, 32'h0,     0);
      tbl[10] = mk(0, 0, 0, 32'h0,        0, 0, 3,  9,  32'h55,       32'h0,      2'b01, 32'h8,     1);
      tbl[11] = mk(0, 1, 9, 32'h77,       0, 0, 3,  3,  32'h55,       32'h55,     2'b11, 32'h8,     0);
      tbl[12] = mk(0, 0, 0, 32'h0,        0, 0, 9,  3,  32'h77,       32'h55,     2'b10, 32'h8,     1);
      tbl[13] = mk(0, 0, 0, 32'h0,        0, 0, 9,  9,  32'h77,       32'h77,     2'b00, 32'h8,     0);
      tbl[14] = mk(0, 1, 3, 32'h66,       1, 10, 0, 0,  32'h0,        32'h0,      2'b00, 32'h8,     0);
      tbl[15] = mk(0, 0, 0, 32'h0,        0, 0, 3,  10, 32'h66,       32'h0,      2'b10, 32'h400,   0);
      tbl[16] = mk(0, 0, 0, 32'h0,        1, 10, 1, 1,  32'h0,        32'h0,      2'b00, 32'h400,   0);
      tbl[17] = mk(0, 0, 0, 32'h0,        0, 0, 10, 10, 32'h0,        32'h0,      2'b11, 32'h400,   0);
      tbl[18] = mk(1, 1, 4, 32'h99,       1, 4, 1,  1,  32'h0,        32'h0,      2'b00, 32'h400,   0);
      tbl[19] = mk(0, 0, 0, 32'h0,        0, 0, 4,  10, 32'h0,        32'h0,      2'b00, 32'h0,     0);

      for (int i = 0; i < 20; i++) begin
         apply(tbl[i], i);
      end

      // Forwarding corner: r2 busy holding 0x11, then written with 0x22 while read on both ports.
      apply(mk(0, 1, 2, 32'h11, 0, 0, 1, 1, 32'h0, 32'h0, 2'b00, 32'h0, 0), 100);
      apply(mk(0, 0, 0, 32'h0, 1, 2, 1, 1, 32'h0, 32'h0, 2'b00, 32'h0, 1), 101);
`ifdef REG_FILE_SB_BYPASS_EN
      v = mk(0, 1, 2, 32'h22, 0, 0, 2, 2, 32'h22, 32'h22, 2'b00, 32'h4, 0);
`else
      v = mk(0, 1, 2, 32'h22, 0, 0, 2, 2, 32'h11, 32'h11, 2'b11, 32'h4, 0);
`endif
      apply(v, 102);
      apply(mk(0, 0, 0, 32'h0, 0, 0, 2, 2, 32'h22, 32'h22, 2'b00, 32'h0, 0), 103);

      // Write plus re-issue of the same register while reading it.
`ifdef REG_FILE_SB_BYPASS_EN
      v = mk(0, 1, 2, 32'h33, 1, 2, 2, 2, 32'h33, 32'h33, 2'b11, 32'h0, 0);
`else
      v = mk(0, 1, 2, 32'h33, 1, 2, 2, 2, 32'h22, 32'h22, 2'b00, 32'h0, 0);
`endif
      apply(v, 104);
      apply(mk(0, 0, 0, 32'h0, 0, 0, 2, 2, 32'h33, 32'h33, 2'b11, 32'h4, 1), 105);
      apply(mk(0, 0, 0, 32'h0, 0, 0, 2, 0, 32'h33, 32'h0, 2'b01, 32'h4, 0), 106);

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
